// File: rtl/dds_multi_ch.sv
// Multi-channel DDS: per-channel phase accumulator, offset, waveform, amplitude; 3-stage pipeline.
// Optional define DDS_DITHER_EN adds a per-channel LFSR phase dither ahead of truncation.
module dds_multi_ch #(
  parameter int NCH    = 2,
  parameter int ACC_W  = 24,
  parameter int OUT_W  = 8,
  parameter int LUT_AW = 8
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 wr,
  input  logic [15:0]          waddr,
  input  logic [15:0]          wdata,
  output logic [NCH*OUT_W-1:0] dout,
  output logic [NCH-1:0]       out_valid
);

  localparam int AMAX  = 2**(OUT_W-1) - 1;
  localparam int LUT_N = 2**LUT_AW;
  // Lowest phase bit any waveform looks at; bits below it never leave S1.
  localparam int PLO   = ((14 - LUT_AW) < (15 - OUT_W)) ? (14 - LUT_AW) : (15 - OUT_W);
  localparam logic signed [OUT_W-1:0] APOS = OUT_W'(AMAX);

  // round(AMAX*sin(pi/2*k/LUT_N)) in Q30 fixed point so it folds to a constant.
  function automatic int rom_val(input int k);
    longint x, term, s;
    x    = 64'sd3373259426 * longint'(k) / longint'(2 * LUT_N);
    term = x;
    s    = x;
    for (int n = 1; n <= 7; n++) begin
      term = (term * x) / 64'sd1073741824;
      term = (term * x) / 64'sd1073741824;
      term = -term / longint'((2 * n) * (2 * n + 1));
      s    = s + term;
    end
    return int'((longint'(AMAX) * s + 64'sd536870912) / 64'sd1073741824);
  endfunction

  logic [OUT_W-1:0] rom [LUT_N];
  for (genvar k = 0; k < LUT_N; k++) begin : g_rom
    localparam int V = rom_val(k);
    assign rom[k] = OUT_W'(V);
  end

  logic sync;
  assign sync = wr && (waddr == 16'h00F0);

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic                    sel;
    logic                    en;
    logic [1:0]              wave;
    logic [15:0]             ftw, poff, dith;
    logic [7:0]              amp, a1, a2;
    logic [ACC_W-1:0]        acc;
    logic [15:PLO]           p1;
    logic [1:0]              w1;
    logic                    v1, v2, v3;
    logic signed [OUT_W-1:0] s2, s3, wave_val, rv, scaled;
    logic [LUT_AW-1:0]       idx;
    logic [OUT_W:0]          tri_t;
    logic [OUT_W-1:0]        tri_u;
    logic signed [OUT_W+9:0] wave_ext, amp_ext, prod;

    assign sel = wr && (waddr[15:8] == 8'd0) && (waddr[7:4] == 4'(c));

`ifdef DDS_DITHER_EN
    logic [15:0] lfsr;
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) lfsr <= 16'hACE1 + 16'(c);
      else if (en) lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    end
    assign dith = lfsr & 16'((1 << (14 - LUT_AW)) - 1);
`else
    assign dith = 16'd0;
`endif

    // SYNC beats increment; a same-edge FTW write lands after this edge's increment.
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        en   <= 1'b0;
        wave <= 2'b00;
        ftw  <= 16'd0;
        poff <= 16'd0;
        amp  <= 8'hFF;
        acc  <= '0;
      end else begin
        if (sel) begin
          case (waddr[3:0])
            4'h0: begin en <= wdata[0]; wave <= wdata[2:1]; end
            4'h1: ftw  <= wdata;
            4'h2: poff <= wdata;
            4'h3: amp  <= wdata[7:0];
            default: ;
          endcase
        end
        if (sync)    acc <= '0;
        else if (en) acc <= acc + ACC_W'(ftw);
      end
    end

    always_comb begin
      idx = p1[13 -: LUT_AW];
      if (p1[14]) idx = ~idx;
      rv    = $signed(rom[idx]);
      tri_t = p1[15 -: OUT_W+1];
      tri_u = tri_t[OUT_W] ? ~tri_t[OUT_W-1:0] : tri_t[OUT_W-1:0];
      case (w1)
        2'b00:   wave_val = p1[15] ? -rv : rv;
        2'b01:   wave_val = p1[15] ? -APOS : APOS;
        2'b10:   wave_val = $signed({~tri_u[OUT_W-1], tri_u[OUT_W-2:0]});
        default: wave_val = $signed({~p1[15], p1[14 -: OUT_W-1]});
      endcase
    end

    // Signed sample times unsigned (AMP+1), then floor-divide by 256.
    always_comb begin
      wave_ext = (OUT_W+10)'(s2);
      amp_ext  = (OUT_W+10)'({1'b0, a2} + 9'd1);
      prod     = wave_ext * amp_ext;
      scaled   = prod[OUT_W+7:8];
    end

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        p1 <= '0;
        w1 <= 2'b00;
        a1 <= 8'd0;
        v1 <= 1'b0;
        s2 <= '0;
        a2 <= 8'd0;
        v2 <= 1'b0;
        s3 <= '0;
        v3 <= 1'b0;
      end else begin
        p1 <= (16 - PLO)'((acc[ACC_W-1 -: 16] + poff + dith) >> PLO);
        w1 <= wave;
        a1 <= amp;
        v1 <= en;
        s2 <= wave_val;
        a2 <= a1;
        v2 <= v1;
        s3 <= v2 ? scaled : '0;
        v3 <= v2;
      end
    end

    assign dout[c*OUT_W +: OUT_W] = s3;
    assign out_valid[c]           = v3;
  end

endmodule
